iodelay2_ctrl: RTL and testbench
================================

IODELAY2_CTRL -- requirements
Module: iodelay2_ctrl

Interface
REQ-001 The block SHALL take parameter COUNTER_WRAPAROUND, default 1; 1 means tap count wraps at its limits, 0 means it stays at the limit.
REQ-002 The block SHALL take parameter MAX_TAP, default 255, giving the highest legal tap count (1..255).
REQ-003 The block SHALL take parameter BUSY_RISE_WAIT, default 4, giving the number of cycles to wait for dly_busy to rise after CAL.
REQ-004 The block SHALL take parameter BUSY_TIMEOUT, default 1023, giving the maximum number of cycles to wait for dly_busy to fall.
REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port start_cal, input, 1 bit: requests recalibration.
REQ-008 The block SHALL have ports inc_req and dec_req, inputs, 1 bit each: tap step requests.
REQ-009 The block SHALL have port req_ready, output, 1 bit: requests are accepted in this cycle.
REQ-010 The block SHALL have port tap, output, 8 bits: the current tap count.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port timeout_err, output, 1 bit: sticky busy-timeout flag.
REQ-013 The block SHALL have ports dly_cal, dly_ce, dly_inc and dly_rst, outputs, 1 bit each, driving the delay element's CAL, CE, INC and RST inputs.
REQ-014 The block SHALL have port dly_busy, input, 1 bit, driven by the delay element's BUSY output.

Function
REQ-015 FSM states SHALL be: CAL, WAIT_HI, WAIT_LO, DRST, READY, ADJ, HOLD.
- CAL: dly_cal=1 for exactly 1 cycle, then WAIT_HI.
- WAIT_HI: go to WAIT_LO when dly_busy=1 or after BUSY_RISE_WAIT cycles, whichever comes first.
- WAIT_LO: go to DRST when dly_busy=0.
REQ-016 DRST SHALL: drive dly_rst=1 for 1 cycle, load tap to 0, pulse done, then go to READY.
REQ-017 req_ready SHALL be 1 only in READY.
REQ-018 Requests in READY SHALL be prioritised: start_cal first, which goes to CAL and discards inc/dec; then exactly one of inc_req/dec_req, which goes to ADJ; inc_req and dec_req both high is ignored and the FSM stays in READY.
REQ-019 ADJ (one cycle) SHALL:
- drive dly_ce=1, with dly_inc=1 for inc and 0 for dec;
- update tap in the same cycle;
- pulse done;
- then go to HOLD (1 cycle), then READY.
- Request accepted at cycle N: CE/done at N+1, req_ready again at N+3.
REQ-020 With COUNTER_WRAPAROUND=1, an increment at MAX_TAP SHALL give tap 0, and a decrement at 0 SHALL give tap MAX_TAP; dly_ce still pulses.
REQ-021 With COUNTER_WRAPAROUND=0, a step past either limit SHALL leave tap unchanged, suppress dly_ce, and still pulse done.
REQ-022 Requests outside READY SHALL be ignored and not queued.
REQ-023 tap arithmetic SHALL be 8-bit unsigned, compared against MAX_TAP, never exceeding it.
REQ-024 dly_ce, dly_cal and dly_rst SHALL never be high in the same cycle.

Reset
REQ-025 While RST=1: state=CAL with dly_cal held 0, all outputs 0, tap=0, timeout_err=0, timers cleared.
REQ-026 On the first cycle with RST=0, the FSM SHALL execute CAL with dly_cal=1.
REQ-027 RST asserted in any state SHALL abort the operation in the next cycle with no further pulses.

Configuration
REQ-028 With IODELAY2_CTRL_TIMEOUT_EN defined, WAIT_LO SHALL count cycles; on reaching BUSY_TIMEOUT it SHALL set timeout_err (cleared only by RST) and proceed to DRST.
REQ-029 Without IODELAY2_CTRL_TIMEOUT_EN, WAIT_LO SHALL wait indefinitely, timeout_err SHALL be tied 0, and no timeout counter logic SHALL exist.

Structure
REQ-030 Package iodelay2_ctrl_pkg SHALL hold the FSM state encoding, TAP_W=8, and the default BUSY_RISE_WAIT and BUSY_TIMEOUT constants.
REQ-031 A single sub-module, iodelay2_busy_timer (load/count/expire), SHALL serve both WAIT_HI and WAIT_LO.

Verification
REQ-032 Calibration with dly_busy stuck at 0: RST released at cycle 0 -> dly_cal=1 at cycle 0, dly_rst/done at cycle 5, req_ready=1 at cycle 6, tap=0.
REQ-033 Busy handshake: dly_busy high for cycles 2..20 after CAL -> dly_rst one cycle after dly_busy falls; timeout_err=0.
REQ-034 Wrap: 256 inc_req with COUNTER_WRAPAROUND=1, MAX_TAP=255 -> tap sequence 1..255,0, 256 dly_ce pulses, each dly_inc=1; then 1 dec -> tap 255.
REQ-035 Stay-at-limit: COUNTER_WRAPAROUND=0, dec_req at tap 0 -> done=1, dly_ce=0, tap=0; inc_req and dec_req together -> no action, req_ready stays 1.
REQ-036 Timeout (macro on, BUSY_TIMEOUT=15): dly_busy held at 1 -> timeout_err=1 after 15 WAIT_LO cycles, then DRST and READY; recovers only after RST.
REQ-037 Mid-operation reset: RST asserted in ADJ cycle -> next cycle all outputs 0, tap=0; start_cal together with inc_req in READY -> CAL, tap unchanged until DRST.

Source files
------------

// File: rtl/iodelay2_ctrl_pkg.sv
// Shared types and constants for the IODELAY2 calibration/step controller.
package iodelay2_ctrl_pkg;

    localparam int unsigned TAP_W              = 8;
    localparam int unsigned DEF_BUSY_RISE_WAIT = 4;
    localparam int unsigned DEF_BUSY_TIMEOUT   = 1023;

    typedef enum logic [2:0] {
        S_CAL     = 3'd0,
        S_WAIT_HI = 3'd1,
        S_WAIT_LO = 3'd2,
        S_DRST    = 3'd3,
        S_READY   = 3'd4,
        S_ADJ     = 3'd5,
        S_HOLD    = 3'd6
    } state_e;

endpackage

// File: rtl/iodelay2_ctrl_if.sv
// Request side and delay-element side signals of the controller.
// master: the controller; slave: the user logic plus the delay element.
interface iodelay2_ctrl_if;
    import iodelay2_ctrl_pkg::*;

    logic             start_cal;
    logic             inc_req;
    logic             dec_req;
    logic             req_ready;
    logic [TAP_W-1:0] tap;
    logic             done;
    logic             timeout_err;
    logic             dly_cal;
    logic             dly_ce;
    logic             dly_inc;
    logic             dly_rst;
    logic             dly_busy;

    modport master (
        input  start_cal, inc_req, dec_req, dly_busy,
        output req_ready, tap, done, timeout_err,
        output dly_cal, dly_ce, dly_inc, dly_rst
    );

    modport slave (
        output start_cal, inc_req, dec_req, dly_busy,
        input  req_ready, tap, done, timeout_err,
        input  dly_cal, dly_ce, dly_inc, dly_rst
    );
endinterface

// File: rtl/iodelay2_busy_timer.sv
// Up-counting wait timer shared by the busy-rise and busy-fall waits.
// load clears the count; en advances it; expired_c flags count >= limit.
module iodelay2_busy_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expired_c
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_c = (cnt_q >= limit);

    // Next count: clear on load, advance when enabled, saturate once expired.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en && !expired_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/iodelay2_ctrl.sv
// IODELAY2 controller: calibrates the delay element, then serves tap inc/dec
// requests. Define IODELAY2_CTRL_TIMEOUT_EN to bound the busy-fall wait and
// raise a sticky timeout_err.
module iodelay2_ctrl
    import iodelay2_ctrl_pkg::*;
#(
    parameter int unsigned COUNTER_WRAPAROUND = 1,
    parameter int unsigned MAX_TAP            = 255,
    parameter int unsigned BUSY_RISE_WAIT     = DEF_BUSY_RISE_WAIT,
    parameter int unsigned BUSY_TIMEOUT       = DEF_BUSY_TIMEOUT
) (
    input logic            CLK,
    input logic            RST,
    iodelay2_ctrl_if.master bus
);
    // Counter sized for the longer of the two waits.
    localparam int unsigned CNT_MAX  = (BUSY_TIMEOUT > BUSY_RISE_WAIT) ? BUSY_TIMEOUT : BUSY_RISE_WAIT;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1) + 1;
    localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(MAX_TAP);
    localparam logic [CNT_W-1:0] RISE_LIM = CNT_W'(BUSY_RISE_WAIT - 1);

    state_e           state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic             ce_q, ce_d;
    logic             inc_q, inc_d;
    logic             done_q, done_d;
    logic             drst_q, drst_d;
    logic             ready_q, ready_d;
    logic             tm_load, tm_en, tm_exp;
    logic [CNT_W-1:0] tm_limit;
`ifdef IODELAY2_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(BUSY_TIMEOUT - 1);
    logic             terr_q, terr_d;
`endif

    // The rise wait counts from the CAL cycle; the fall wait from WAIT_LO entry.
`ifdef IODELAY2_CTRL_TIMEOUT_EN
    assign tm_limit = (state_q == S_WAIT_LO) ? TO_LIM : RISE_LIM;
`else
    assign tm_limit = RISE_LIM;
`endif

    iodelay2_busy_timer #(.CNT_W(CNT_W)) u_timer (
        .clk       (CLK),
        .rst       (RST),
        .load      (tm_load),
        .en        (tm_en),
        .limit     (tm_limit),
        .expired_c (tm_exp)
    );

    // Next state, tap arithmetic and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        ce_d    = 1'b0;
        inc_d   = 1'b0;
`ifdef IODELAY2_CTRL_TIMEOUT_EN
        terr_d  = terr_q;
`endif
        case (state_q)
            S_CAL:     state_d = S_WAIT_HI;
            S_WAIT_HI: if (bus.dly_busy || tm_exp) state_d = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!bus.dly_busy) begin
                    state_d = S_DRST;
`ifdef IODELAY2_CTRL_TIMEOUT_EN
                end else if (tm_exp) begin
                    state_d = S_DRST;
                    terr_d  = 1'b1;
`endif
                end
            end
            S_DRST:    state_d = S_READY;
            S_READY: begin
                if (bus.start_cal) begin
                    state_d = S_CAL;
                end else if (bus.inc_req ^ bus.dec_req) begin
                    state_d = S_ADJ;
                    ce_d    = 1'b1;
                    if (bus.inc_req) begin
                        if (tap_q >= TAP_MAX) begin
                            if (COUNTER_WRAPAROUND != 0) tap_d = '0;
                            else                         ce_d  = 1'b0;
                        end else begin
                            tap_d = tap_q + TAP_W'(1);
                        end
                    end else begin
                        if (tap_q == '0) begin
                            if (COUNTER_WRAPAROUND != 0) tap_d = TAP_MAX;
                            else                         ce_d  = 1'b0;
                        end else begin
                            tap_d = tap_q - TAP_W'(1);
                        end
                    end
                    inc_d = bus.inc_req & ce_d;
                end
            end
            S_ADJ:     state_d = S_HOLD;
            S_HOLD:    state_d = S_READY;
            default:   state_d = S_CAL;
        endcase

        if (state_d == S_DRST) tap_d = '0;

`ifdef IODELAY2_CTRL_TIMEOUT_EN
        tm_en = (state_d == S_WAIT_HI) || (state_q == S_WAIT_LO && state_d == S_WAIT_LO);
`else
        tm_en = (state_d == S_WAIT_HI);
`endif
        tm_load = !tm_en;

        drst_d  = (state_d == S_DRST);
        done_d  = (state_d == S_DRST) || (state_d == S_ADJ);
        ready_d = (state_d == S_READY);
    end

    // State and output registers; reset parks in CAL with everything cleared.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_CAL;
            tap_q   <= '0;
            ce_q    <= 1'b0;
            inc_q   <= 1'b0;
            done_q  <= 1'b0;
            drst_q  <= 1'b0;
            ready_q <= 1'b0;
`ifdef IODELAY2_CTRL_TIMEOUT_EN
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            ce_q    <= ce_d;
            inc_q   <= inc_d;
            done_q  <= done_d;
            drst_q  <= drst_d;
            ready_q <= ready_d;
`ifdef IODELAY2_CTRL_TIMEOUT_EN
            terr_q  <= terr_d;
`endif
        end
    end

    // CAL must fire in the very first cycle after reset drops, so it is the
    // one output decoded from state and gated by the live reset input.
    assign bus.dly_cal   = (state_q == S_CAL) && !RST;
    assign bus.dly_ce    = ce_q;
    assign bus.dly_inc   = inc_q;
    assign bus.dly_rst   = drst_q;
    assign bus.done      = done_q;
    assign bus.req_ready = ready_q;
    assign bus.tap       = tap_q;
`ifdef IODELAY2_CTRL_TIMEOUT_EN
    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_iodelay2_ctrl.sv
// Directed bench for iodelay2_ctrl: dut_a wraps (MAX_TAP=255), dut_b saturates
// (MAX_TAP=5, BUSY_TIMEOUT=15). Outputs are sampled 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_iodelay2_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    iodelay2_ctrl_if a_if ();
    iodelay2_ctrl_if b_if ();

    iodelay2_ctrl #(.COUNTER_WRAPAROUND(1), .MAX_TAP(255), .BUSY_RISE_WAIT(4), .BUSY_TIMEOUT(1023))
        dut_a (.CLK(CLK), .RST(RST), .bus(a_if.master));
    iodelay2_ctrl #(.COUNTER_WRAPAROUND(0), .MAX_TAP(5), .BUSY_RISE_WAIT(4), .BUSY_TIMEOUT(15))
        dut_b (.CLK(CLK), .RST(RST), .bus(b_if.master));

    typedef struct {
        logic       sel;   // 0: dut_a, 1: dut_b
        logic       inc;
        logic       dec;
        logic       act;   // request expected to be taken
        logic       ce;
        logic [7:0] tap;
    } vec_t;

    vec_t vecs[16];

    // Observation word: {ready, done, cal, ce, inc, drst, terr, tap[7:0]}
    function automatic logic [14:0] mk(input logic rdy, input logic dn, input logic cal,
                                       input logic ce, input logic inc, input logic drst,
                                       input logic terr, input logic [7:0] tap);
        return {rdy, dn, cal, ce, inc, drst, terr, tap};
    endfunction

    function automatic logic [14:0] obs(input logic sel);
        if (sel)
            return {b_if.req_ready, b_if.done, b_if.dly_cal, b_if.dly_ce, b_if.dly_inc,
                    b_if.dly_rst, b_if.timeout_err, b_if.tap};
        return {a_if.req_ready, a_if.done, a_if.dly_cal, a_if.dly_ce, a_if.dly_inc,
                a_if.dly_rst, a_if.timeout_err, a_if.tap};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input logic sel, input logic s, input logic i, input logic d);
        if (sel) begin
            b_if.start_cal = s; b_if.inc_req = i; b_if.dec_req = d;
        end else begin
            a_if.start_cal = s; a_if.inc_req = i; a_if.dec_req = d;
        end
    endtask

    // Called in the first window with RST low and busy low on both DUTs.
    task automatic calib_seq(input string tag);
        for (int s = 0; s < 2; s++)
            check($sformatf("%s cal c0 dut%0d", tag, s), 32'(obs(1'(s))), 32'(mk(0,0,1,0,0,0,0,8'd0)));
        tick();
        check({tag, " c1 no cal"}, 32'(obs(1'b0)), 32'(mk(0,0,0,0,0,0,0,8'd0)));
        for (int c = 2; c <= 5; c++) tick();
        for (int s = 0; s < 2; s++)
            check($sformatf("%s drst c5 dut%0d", tag, s), 32'(obs(1'(s))), 32'(mk(0,1,0,0,0,1,0,8'd0)));
        tick();
        for (int s = 0; s < 2; s++)
            check($sformatf("%s ready c6 dut%0d", tag, s), 32'(obs(1'(s))), 32'(mk(1,0,0,0,0,0,0,8'd0)));
    endtask

    initial begin
        logic [14:0] o;
        int          found;
        vec_t        v;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd255};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd4};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd5};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd5};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd4};

        set_req(1'b0, 0, 0, 0); set_req(1'b1, 0, 0, 0);
        a_if.dly_busy = 1'b0;   b_if.dly_busy = 1'b0;

        // Reset state
        RST = 1'b1;
        repeat (3) tick();
        check("reset a", 32'(obs(1'b0)), 32'(mk(0,0,0,0,0,0,0,8'd0)));
        check("reset b", 32'(obs(1'b1)), 32'(mk(0,0,0,0,0,0,0,8'd0)));
        RST = 1'b0;
        #1;
        calib_seq("boot");

        // Step requests from the vector table
        foreach (vecs[i]) begin
            v = vecs[i];
            o = obs(v.sel);
            check($sformatf("vec%0d ready", i), 32'(o[14]), 32'd1);
            set_req(v.sel, 0, v.inc, v.dec);
            tick();
            set_req(v.sel, 0, 0, 0);
            if (v.act) begin
                check($sformatf("vec%0d adj", i), 32'(obs(v.sel)), 32'(mk(0,1,0,v.ce,v.inc & v.ce,0,0,v.tap)));
                tick();
                check($sformatf("vec%0d hold", i), 32'(obs(v.sel)), 32'(mk(0,0,0,0,0,0,0,v.tap)));
                tick();
            end else begin
                check($sformatf("vec%0d idle", i), 32'(obs(v.sel)), 32'(mk(1,0,0,0,0,0,0,v.tap)));
            end
        end

        // Full wrap: 256 increments from tap 0, then one decrement
        for (int i = 0; i < 256; i++) begin
            set_req(1'b0, 0, 1, 0);
            tick();
            set_req(1'b0, 0, 0, 0);
            check($sformatf("wrap inc %0d", i), 32'(obs(1'b0)), 32'(mk(0,1,0,1,1,0,0,8'(i + 1))));
            tick(); tick();
        end
        set_req(1'b0, 0, 0, 1);
        tick();
        set_req(1'b0, 0, 0, 0);
        check("wrap dec to max", 32'(obs(1'b0)), 32'(mk(0,1,0,1,0,0,0,8'd255)));
        tick(); tick();

        // Requests outside READY are dropped, not queued
        set_req(1'b0, 0, 0, 1);
        tick();
        set_req(1'b0, 0, 1, 0);
        tick();
        tick();
        set_req(1'b0, 0, 0, 0);
        check("noqueue ready", 32'(obs(1'b0)), 32'(mk(1,0,0,0,0,0,0,8'd254)));
        tick();
        check("noqueue idle", 32'(obs(1'b0)), 32'(mk(1,0,0,0,0,0,0,8'd254)));

        // start_cal wins over inc_req; busy high cycles 2..20 after CAL
        set_req(1'b0, 1, 1, 0);
        tick();
        set_req(1'b0, 0, 0, 0);
        check("recal c0", 32'(obs(1'b0)), 32'(mk(0,0,1,0,0,0,0,8'd254)));
        found = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            a_if.dly_busy = (c >= 2 && c <= 20);
            o = obs(1'b0);
            if (c == 21) check("recal tap kept", 32'(o[7:0]), 32'd254);
            if (o[9]) begin
                found = c;
                check("recal drst word", 32'(o), 32'(mk(0,1,0,0,0,1,0,8'd0)));
                break;
            end
        end
        check("recal drst cycle", 32'(found), 32'd22);
        tick();
        check("recal ready", 32'(obs(1'b0)), 32'(mk(1,0,0,0,0,0,0,8'd0)));

        // Reset in the ADJ cycle aborts
        set_req(1'b0, 0, 1, 0);
        tick();
        set_req(1'b0, 0, 0, 0);
        check("pre-abort adj", 32'(obs(1'b0)), 32'(mk(0,1,0,1,1,0,0,8'd1)));
        RST = 1'b1;
        tick();
        check("abort a", 32'(obs(1'b0)), 32'(mk(0,0,0,0,0,0,0,8'd0)));
        check("abort b", 32'(obs(1'b1)), 32'(mk(0,0,0,0,0,0,0,8'd0)));
        RST = 1'b0;
        #1;
        calib_seq("abort");

        // Busy stuck high on dut_b
        b_if.dly_busy = 1'b1;
        set_req(1'b1, 1, 0, 0);
        tick();
        set_req(1'b1, 0, 0, 0);
        check("stuck c0", 32'(obs(1'b1)), 32'(mk(0,0,1,0,0,0,0,8'd0)));
        found = -1;
`ifdef IODELAY2_CTRL_TIMEOUT_EN
        for (int c = 1; c <= 40; c++) begin
            tick();
            o = obs(1'b1);
            if (o[9]) begin
                found = c;
                check("timeout drst word", 32'(o), 32'(mk(0,1,0,0,0,1,1,8'd0)));
                break;
            end
        end
        check("timeout cycle", 32'(found), 32'd17);
        tick();
        check("timeout ready", 32'(obs(1'b1)), 32'(mk(1,0,0,0,0,0,1,8'd0)));
        b_if.dly_busy = 1'b0;
        tick();
        check("timeout sticky", 32'(obs(1'b1)), 32'(mk(1,0,0,0,0,0,1,8'd0)));
`else
        for (int c = 1; c <= 40; c++) begin
            tick();
            o = obs(1'b1);
            if (o[9] || o[6]) begin
                found = c;
                break;
            end
        end
        check("no timeout", 32'(found), 32'hFFFF_FFFF);
        b_if.dly_busy = 1'b0;
        tick();
        check("late drst", 32'(obs(1'b1)), 32'(mk(0,1,0,0,0,1,0,8'd0)));
        tick();
`endif

        // Reset clears everything including the timeout flag
        RST = 1'b1;
        tick();
        check("final reset b", 32'(obs(1'b1)), 32'(mk(0,0,0,0,0,0,0,8'd0)));
        RST = 1'b0;
        #1;
        calib_seq("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
